// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver producing the 11-bit toggle-event ps2_key bus.
// Pins are synchronised and glitch-filtered. Frames are deserialised on the
// filtered falling edges. A prefix FSM folds E0/F0/E1 sequences into
// single key events.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_edge;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          rx_err;
    logic          frame_err_q, frame_err_d;
    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   ps2_key_q, ps2_key_d;
    logic          emit, emit_ext, emit_pressed;
    logic [7:0]    emit_code;

    // Synchronise the pins and debounce the PS/2 clock into a clean level
    always_comb begin
        clk_meta_d  = ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data_in;
        data_sync_d = data_meta_q;
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        fall_edge = filt_clk_q & ~filt_clk_d;
    end

    // Shift in frame bits on falling edges, validate the frame, abort stalled frames
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        rx_err       = 1'b0;
        if (fall_edge) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!shift_q[0] && data_sync_q && (^shift_q[9:1])) begin
                    byte_valid_d = 1'b1;
                    byte_d       = shift_q[8:1];
                end else begin
                    rx_err = 1'b1;
                end
            end else begin
                shift_d   = {data_sync_q, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                to_cnt_d  = '0;
                bit_cnt_d = 4'd0;
                rx_err    = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
        frame_err_d = rx_err;
    end

    // Prefix FSM: fold E0/F0/E1 prefixes into one key event per keystroke
    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        ps2_key_d    = ps2_key_q;
        emit         = 1'b0;
        emit_ext     = 1'b0;
        emit_pressed = 1'b0;
        emit_code    = byte_q;
        if (rx_err) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
        end else if (byte_valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (byte_q == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (byte_q == 8'hE1) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end else begin
                        emit         = 1'b1;
                        emit_pressed = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_q != 8'hE0) begin
                        emit         = 1'b1;
                        emit_ext     = 1'b1;
                        emit_pressed = 1'b1;
                    end
                end
                ST_BRK: begin
                    emit = 1'b1;
                end
                ST_EXT_BRK: begin
                    emit     = 1'b1;
                    emit_ext = 1'b1;
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        emit         = 1'b1;
                        emit_ext     = 1'b1;
                        emit_pressed = 1'b1;
                        emit_code    = 8'h77;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (emit) begin
                state_d = ST_IDLE;
                if (!(emit_ext && (emit_code == 8'h12 || emit_code == 8'h59))) begin
                    ps2_key_d = {~ps2_key_q[10], emit_pressed, emit_ext, emit_code};
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            data_meta_q  <= 1'b1;
            data_sync_q  <= 1'b1;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'd0;
            frame_err_q  <= 1'b0;
            state_q      <= ST_IDLE;
            skip_q       <= 3'd0;
            ps2_key_q    <= 11'd0;
        end else begin
            clk_meta_q   <= clk_meta_d;
            clk_sync_q   <= clk_sync_d;
            data_meta_q  <= data_meta_d;
            data_sync_q  <= data_sync_d;
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            skip_q       <= skip_d;
            ps2_key_q    <= ps2_key_d;
        end
    end

    assign ps2_key   = ps2_key_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: drives PS/2 frames onto the pins and compares
// ps2_key/frame_err against a keystroke-level reference model.
module tb_ps2_key_encoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 25;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [10:0] ps2_key;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    int cycle_cnt       = 0;
    int event_cnt       = 0;
    int change_cnt      = 0;
    int err_cnt         = 0;
    int wide_err        = 0;
    int clash_cnt       = 0;
    int last_err_cycle  = 0;
    int last_fall_cycle = 0;
    logic [10:0] prev_key = 11'd0;
    logic        prev_err = 1'b0;

    // Reference model state: expected bus value, event count, error count, pending prefixes
    logic [10:0] exp_key    = 11'd0;
    int          exp_events = 0;
    int          exp_errs   = 0;
    bit          m_ext      = 1'b0;
    bit          m_brk      = 1'b0;
    int          m_pause    = 0;

    ps2_key_encoder #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_key    (ps2_key),
        .frame_err  (frame_err)
    );

    // Free-running system clock
    always #5 clk_sys = ~clk_sys;

    // Monitor events, bus changes and error pulses away from the active edge
    always @(negedge clk_sys) begin
        cycle_cnt++;
        if (!reset) begin
            if (ps2_key[10] !== prev_key[10]) event_cnt++;
            if (ps2_key !== prev_key) change_cnt++;
            if (frame_err) begin
                err_cnt++;
                last_err_cycle = cycle_cnt;
                if (prev_err) wide_err++;
                if (ps2_key[10] !== prev_key[10]) clash_cnt++;
            end
        end
        prev_key = ps2_key;
        prev_err = frame_err;
    end

    function automatic void model_emit(logic [7:0] code, bit ext, bit pressed);
        m_ext = 1'b0;
        m_brk = 1'b0;
        if (!(ext && (code == 8'h12 || code == 8'h59))) begin
            exp_key = {~exp_key[10], pressed, ext, code};
            exp_events++;
        end
    endfunction

    function automatic void model_byte(logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) model_emit(8'h77, 1'b1, 1'b1);
        end else if (m_brk) begin
            model_emit(b, m_ext, 1'b0);
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) model_emit(b, 1'b1, 1'b1);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_pause = 7;
        end else begin
            model_emit(b, 1'b0, 1'b1);
        end
    endfunction

    function automatic void model_abort();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
    endfunction

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic settle();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(logic b, bit glitch);
        ps2_data_in = b;
        if (glitch) begin
            wait_cycles(8);
            ps2_clk_in = 1'b0;
            wait_cycles(3);
            ps2_clk_in = 1'b1;
            wait_cycles(HALF - 11);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk_in      = 1'b0;
        last_fall_cycle = cycle_cnt;
        if (glitch) begin
            wait_cycles(8);
            ps2_clk_in = 1'b1;
            wait_cycles(3);
            ps2_clk_in = 1'b0;
            wait_cycles(HALF - 11);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk_in = 1'b1;
    endtask

    task automatic applyStimulus(logic [7:0] b, bit bad_par, int nbits, bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i], glitch && (i == 3 || i == 6));
        wait_cycles(30);
    endtask

    task automatic send_byte(logic [7:0] b);
        applyStimulus(b, 1'b0, 11, 1'b0);
        model_byte(b);
    endtask

    task automatic check_state(string tag);
        settle();
        checkOutput({tag, "_key"}, {21'd0, ps2_key}, {21'd0, exp_key});
        checkOutput({tag, "_events"}, event_cnt, exp_events);
        checkOutput({tag, "_errs"}, err_cnt, exp_errs);
    endtask

    initial begin
        logic [7:0] code;
        int kind;
        int delta;

        reset       = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        wait_cycles(5);
        settle();
        checkOutput("reset_key", {21'd0, ps2_key}, 32'd0);
        checkOutput("reset_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        wait_cycles(20);

        $display("[TB] single make code 1C");
        send_byte(8'h1C);
        check_state("make_1c");
        checkOutput("make_1c_low", {22'd0, ps2_key[9:0]}, 32'h21C);

        $display("[TB] extended break E0 F0 75");
        send_byte(8'hE0);
        check_state("e0_prefix");
        send_byte(8'hF0);
        check_state("f0_prefix");
        send_byte(8'h75);
        check_state("ext_brk_75");
        checkOutput("ext_brk_75_low", {22'd0, ps2_key[9:0]}, 32'h175);

        $display("[TB] parity error on 29");
        applyStimulus(8'h29, 1'b1, 11, 1'b0);
        model_abort();
        exp_errs++;
        check_state("parity_err");
        send_byte(8'hF0);
        send_byte(8'h29);
        check_state("brk_29");
        checkOutput("brk_29_low", {22'd0, ps2_key[9:0]}, 32'h029);

        $display("[TB] partial frame then stall");
        applyStimulus(8'h16, 1'b0, 5, 1'b0);
        wait_cycles(TIMEOUT + 100);
        model_abort();
        exp_errs++;
        check_state("timeout");
        delta = last_err_cycle - last_fall_cycle;
        checkOutput("timeout_delay", {31'd0, (delta >= TIMEOUT && delta <= TIMEOUT + 20)}, 32'd1);
        send_byte(8'h16);
        check_state("after_timeout");
        checkOutput("after_timeout_low", {22'd0, ps2_key[9:0]}, 32'h216);

        $display("[TB] pause sequence and fake shift");
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        check_state("pause");
        checkOutput("pause_low", {22'd0, ps2_key[9:0]}, 32'h377);
        send_byte(8'hE0);
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'h7C);
        check_state("fake_shift");
        checkOutput("fake_shift_low", {22'd0, ps2_key[9:0]}, 32'h37C);

        $display("[TB] glitched clock mid-frame");
        applyStimulus(8'h3A, 1'b0, 11, 1'b1);
        model_byte(8'h3A);
        check_state("glitch");

        $display("[TB] reset mid-frame");
        applyStimulus(8'h5A, 1'b0, 5, 1'b0);
        reset = 1'b1;
        wait_cycles(3);
        settle();
        checkOutput("midreset_key", {21'd0, ps2_key}, 32'd0);
        checkOutput("midreset_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        exp_key = 11'd0;
        model_abort();
        wait_cycles(20);
        send_byte(8'h1C);
        check_state("after_reset");
        checkOutput("after_reset_low", {22'd0, ps2_key[9:0]}, 32'h21C);

        $display("[TB] random keystrokes");
        for (int n = 0; n < 14; n++) begin
            kind = $urandom_range(0, 4);
            do code = 8'($urandom_range(0, 255));
            while (code == 8'hE0 || code == 8'hF0 || code == 8'hE1);
            if ($urandom_range(0, 3) == 0) code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
            case (kind)
                0: send_byte(code);
                1: begin send_byte(8'hE0); send_byte(code); end
                2: begin send_byte(8'hF0); send_byte(code); end
                3: begin send_byte(8'hE0); send_byte(8'hF0); send_byte(code); end
                default: begin
                    applyStimulus(code, 1'b1, 11, 1'b0);
                    model_abort();
                    exp_errs++;
                end
            endcase
            check_state("random");
        end

        settle();
        checkOutput("err_width", wide_err, 32'd0);
        checkOutput("err_emit_clash", clash_cnt, 32'd0);
        checkOutput("changes_vs_events", change_cnt, exp_events);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
